pipeline_stage_regs: RTL and testbench

- Pipeline register chain for the 5-stage RISC-V core: IF/ID, ID/EX, EX/MEM and MEM/WB registers for the PC, instruction, register addresses and control fields.
- Consumes the hazard controls (StallF, StallD, FlushD, FlushE).
- Produces the stage-tagged register addresses and write-enables that hazard detection and forwarding read: Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE0.
- Also counts retired instructions and bubbles for performance debug.

---
 rtl/pipeline_stage_regs_pkg.sv | 52 +++++
 rtl/pipeline_stage_regs_if.sv | 53 +++++
 rtl/pipeline_stage_regs_pipe_reg.sv | 26 ++
 rtl/pipeline_stage_regs.sv | 133 +++++++++++++
 tb/tb_pipeline_stage_regs.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stage_regs_pkg.sv
// Shared constants and stage-record types for the 5-stage pipeline register chain.
package pipeline_stage_regs_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          REG_ADDR_W = 5;
  localparam int          RS1_LSB    = 15;
  localparam int          RS2_LSB    = 20;
  localparam int          RD_LSB     = 7;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '{reg_write: 1'b0, mem_write: 1'b0, result_src: RES_ALU};

  typedef struct packed {
    logic      valid;
    ctrl_t     ctrl;
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
  } id_ex_t;

  typedef struct packed {
    logic      valid;
    ctrl_t     ctrl;
    reg_addr_t rd;
  } ex_mem_t;

  // Stores are finished by W, so the writeback record drops mem_write.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    reg_addr_t  rd;
  } mem_wb_t;

  function automatic reg_addr_t reg_field(input logic [31:0] instr, input int lsb);
    return instr[lsb +: REG_ADDR_W];
  endfunction

endpackage

// File: rtl/pipeline_stage_regs_if.sv
// Hazard controls, fetch/decode inputs and stage-tagged outputs of the pipeline register chain.
interface pipeline_stage_regs_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            StallF;
  logic            StallD;
  logic            FlushD;
  logic            FlushE;
  logic [XLEN-1:0] PCNextF;
  logic [31:0]     InstrF;
  logic [XLEN-1:0] PCF;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic            ValidD;
  logic            RegWriteD;
  logic            MemWriteD;
  logic [1:0]      ResultSrcD;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic            RegWriteE;
  logic            MemWriteE;
  logic [1:0]      ResultSrcE;
  logic            ResultSrcE0;
  logic [4:0]      RdM;
  logic            RegWriteM;
  logic            MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RdW;
  logic            RegWriteW;
  logic [1:0]      ResultSrcW;
  logic [CNT_W-1:0] RetiredCnt;
  logic [CNT_W-1:0] BubbleCnt;

  modport master (
    output StallF, StallD, FlushD, FlushE, PCNextF, InstrF,
           RegWriteD, MemWriteD, ResultSrcD,
    input  PCF, InstrD, PCD, ValidD,
           Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, ResultSrcE, ResultSrcE0,
           RdM, RegWriteM, MemWriteM, ResultSrcM,
           RdW, RegWriteW, ResultSrcW, RetiredCnt, BubbleCnt
  );

  modport slave (
    input  StallF, StallD, FlushD, FlushE, PCNextF, InstrF,
           RegWriteD, MemWriteD, ResultSrcD,
    output PCF, InstrD, PCD, ValidD,
           Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, ResultSrcE, ResultSrcE0,
           RdM, RegWriteM, MemWriteM, ResultSrcM,
           RdW, RegWriteW, ResultSrcW, RetiredCnt, BubbleCnt
  );
endinterface

// File: rtl/pipeline_stage_regs_pipe_reg.sv
// Generic stage register: async reset and synchronous clear both load RST_VAL; clear beats enable.
module pipeline_stage_regs_pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RST_VAL;
    end else if (clr_i) begin
      data_q <= RST_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;
endmodule

// File: rtl/pipeline_stage_regs.sv
// PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers plus saturating retired/bubble counters.
module pipeline_stage_regs
  import pipeline_stage_regs_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_stage_regs_if.slave bus
);
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } if_id_t;

  localparam if_id_t  IF_ID_BUBBLE  = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
  localparam id_ex_t  ID_EX_BUBBLE  = '{valid: 1'b0, ctrl: BUBBLE_CTRL, rs1: '0, rs2: '0, rd: '0};
  localparam ex_mem_t EX_MEM_BUBBLE = '{valid: 1'b0, ctrl: BUBBLE_CTRL, rd: '0};
  localparam mem_wb_t MEM_WB_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, result_src: RES_ALU, rd: '0};

  logic [XLEN-1:0] pc_q;
  if_id_t          if_id_d, if_id_q;
  id_ex_t          id_ex_d, id_ex_q;
  ex_mem_t         ex_mem_d, ex_mem_q;
  mem_wb_t         mem_wb_d, mem_wb_q;

  pipeline_stage_regs_pipe_reg #(.W(XLEN), .RST_VAL('0)) u_pc (
    .clk(clk), .rst(rst), .clr_i(1'b0), .en_i(~bus.StallF),
    .d_i(bus.PCNextF), .q_o(pc_q)
  );

  always_comb begin
    if_id_d       = IF_ID_BUBBLE;
    if_id_d.valid = 1'b1;
    if_id_d.pc    = pc_q;
    if_id_d.instr = bus.InstrF;
  end

  pipeline_stage_regs_pipe_reg #(.W($bits(if_id_t)), .RST_VAL(IF_ID_BUBBLE)) u_if_id (
    .clk(clk), .rst(rst), .clr_i(bus.FlushD), .en_i(~bus.StallD),
    .d_i(if_id_d), .q_o(if_id_q)
  );

  // An empty D slot must not leak decoder outputs into E, whatever the decoder says.
  always_comb begin
    id_ex_d       = ID_EX_BUBBLE;
    id_ex_d.valid = if_id_q.valid;
    id_ex_d.rs1   = reg_field(if_id_q.instr, RS1_LSB);
    id_ex_d.rs2   = reg_field(if_id_q.instr, RS2_LSB);
    id_ex_d.rd    = reg_field(if_id_q.instr, RD_LSB);
    if (if_id_q.valid) begin
      id_ex_d.ctrl.reg_write  = bus.RegWriteD;
      id_ex_d.ctrl.mem_write  = bus.MemWriteD;
      id_ex_d.ctrl.result_src = bus.ResultSrcD;
    end
  end

  pipeline_stage_regs_pipe_reg #(.W($bits(id_ex_t)), .RST_VAL(ID_EX_BUBBLE)) u_id_ex (
    .clk(clk), .rst(rst), .clr_i(bus.FlushE), .en_i(1'b1),
    .d_i(id_ex_d), .q_o(id_ex_q)
  );

  always_comb begin
    ex_mem_d       = EX_MEM_BUBBLE;
    ex_mem_d.valid = id_ex_q.valid;
    ex_mem_d.ctrl  = id_ex_q.ctrl;
    ex_mem_d.rd    = id_ex_q.rd;
  end

  pipeline_stage_regs_pipe_reg #(.W($bits(ex_mem_t)), .RST_VAL(EX_MEM_BUBBLE)) u_ex_mem (
    .clk(clk), .rst(rst), .clr_i(1'b0), .en_i(1'b1),
    .d_i(ex_mem_d), .q_o(ex_mem_q)
  );

  always_comb begin
    mem_wb_d            = MEM_WB_BUBBLE;
    mem_wb_d.valid      = ex_mem_q.valid;
    mem_wb_d.reg_write  = ex_mem_q.ctrl.reg_write;
    mem_wb_d.result_src = ex_mem_q.ctrl.result_src;
    mem_wb_d.rd         = ex_mem_q.rd;
  end

  pipeline_stage_regs_pipe_reg #(.W($bits(mem_wb_t)), .RST_VAL(MEM_WB_BUBBLE)) u_mem_wb (
    .clk(clk), .rst(rst), .clr_i(1'b0), .en_i(1'b1),
    .d_i(mem_wb_d), .q_o(mem_wb_q)
  );

  // Slot 0 counts retired instructions, slot 1 counts bubbles; exactly one advances per cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic             hit;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign hit = (gi == 0) ? mem_wb_q.valid : ~mem_wb_q.valid;

    always_comb begin
      cnt_d = cnt_q;
      if (hit && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign bus.PCF         = pc_q;
  assign bus.InstrD      = if_id_q.instr;
  assign bus.PCD         = if_id_q.pc;
  assign bus.ValidD      = if_id_q.valid;
  assign bus.Rs1E        = id_ex_q.rs1;
  assign bus.Rs2E        = id_ex_q.rs2;
  assign bus.RdE         = id_ex_q.rd;
  assign bus.RegWriteE   = id_ex_q.ctrl.reg_write;
  assign bus.MemWriteE   = id_ex_q.ctrl.mem_write;
  assign bus.ResultSrcE  = id_ex_q.ctrl.result_src;
  assign bus.ResultSrcE0 = id_ex_q.ctrl.result_src[0];
  assign bus.RdM         = ex_mem_q.rd;
  assign bus.RegWriteM   = ex_mem_q.ctrl.reg_write;
  assign bus.MemWriteM   = ex_mem_q.ctrl.mem_write;
  assign bus.ResultSrcM  = ex_mem_q.ctrl.result_src;
  assign bus.RdW         = mem_wb_q.rd;
  assign bus.RegWriteW   = mem_wb_q.reg_write;
  assign bus.ResultSrcW  = mem_wb_q.result_src;
  assign bus.RetiredCnt  = g_cnt[0].cnt_q;
  assign bus.BubbleCnt   = g_cnt[1].cnt_q;
endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Directed bench for the pipeline register chain: flow, load-use, branch flush, async reset, saturation.
module tb_pipeline_stage_regs;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipeline_stage_regs_if #(.XLEN(32), .CNT_W(32)) bus ();
  pipeline_stage_regs_if #(.XLEN(32), .CNT_W(4))  bus4 ();

  assign bus4.StallF     = bus.StallF;
  assign bus4.StallD     = bus.StallD;
  assign bus4.FlushD     = bus.FlushD;
  assign bus4.FlushE     = bus.FlushE;
  assign bus4.PCNextF    = bus.PCNextF;
  assign bus4.InstrF     = bus.InstrF;
  assign bus4.RegWriteD  = bus.RegWriteD;
  assign bus4.MemWriteD  = bus.MemWriteD;
  assign bus4.ResultSrcD = bus.ResultSrcD;

  pipeline_stage_regs #(.XLEN(32), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  pipeline_stage_regs #(.XLEN(32), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'h13};
  endfunction

  function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'h03};
  endfunction

  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    return {7'd0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'h33};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc_next);
    bus.InstrF  = instr;
    bus.PCNextF = pc_next;
  endtask

  task automatic hazards(input logic sf, input logic sd, input logic fd, input logic fe);
    bus.StallF = sf;
    bus.StallD = sd;
    bus.FlushD = fd;
    bus.FlushE = fe;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hazards(1'b0, 1'b0, 1'b0, 1'b0);
    drive(NOP, 32'd0);
    bus.RegWriteD  = 1'b1;
    bus.MemWriteD  = 1'b0;
    bus.ResultSrcD = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Straight-line flow: addi xk, x(k+10), k for k=1..5.
    do_reset();
    chk("rst_PCF", bus.PCF, 0);
    chk("rst_InstrD", bus.InstrD, NOP);
    chk("rst_ValidD", bus.ValidD, 0);
    chk("rst_RdW", bus.RdW, 0);
    chk("rst_RegWriteW", bus.RegWriteW, 0);
    chk("rst_Retired", bus.RetiredCnt, 0);
    chk("rst_Bubble", bus.BubbleCnt, 0);
    for (int k = 1; k <= 9; k++) begin
      drive((k <= 5) ? addi(k, k + 10, k) : NOP, 32'(4 * k));
      step();
      chk("flow_PCF", bus.PCF, 64'(4 * k));
      if (k <= 5) begin
        chk("flow_InstrD", bus.InstrD, addi(k, k + 10, k));
        chk("flow_PCD", bus.PCD, 64'(4 * (k - 1)));
      end
      if (k == 2) begin
        chk("flow_Rs1E", bus.Rs1E, 11);
        chk("flow_Rs2E", bus.Rs2E, 1);
        chk("flow_RdE", bus.RdE, 1);
        chk("flow_RegWriteE", bus.RegWriteE, 1);
      end
      if (k >= 4 && k <= 8) begin
        chk("flow_RdW", bus.RdW, 64'(k - 3));
        chk("flow_RegWriteW", bus.RegWriteW, 1);
      end
      if (k == 4) begin
        chk("flow_Bubble4", bus.BubbleCnt, 4);
        chk("flow_Retired4", bus.RetiredCnt, 0);
      end
    end
    chk("flow_Retired9", bus.RetiredCnt, 5);
    chk("flow_Bubble9", bus.BubbleCnt, 4);

    // Load-use: lw x6 in E, add x7,x6,x6 in D, one-cycle stall + E bubble.
    do_reset();
    drive(lw(6, 5, 0), 32'd4);
    step();
    drive(add(7, 6, 6), 32'd8);
    bus.ResultSrcD = 2'b01;
    step();
    chk("lu_RdE_lw", bus.RdE, 6);
    chk("lu_ResultSrcE0", bus.ResultSrcE0, 1);
    drive(addi(8, 0, 8), 32'd12);
    bus.ResultSrcD = 2'b00;
    hazards(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("lu_PCF_hold", bus.PCF, 8);
    chk("lu_InstrD_hold", bus.InstrD, add(7, 6, 6));
    chk("lu_RegWriteE", bus.RegWriteE, 0);
    chk("lu_RdE_bubble", bus.RdE, 0);
    chk("lu_ResultSrcE0_bubble", bus.ResultSrcE0, 0);
    chk("lu_RdM", bus.RdM, 6);
    chk("lu_RegWriteM", bus.RegWriteM, 1);
    hazards(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("lu_PCF_go", bus.PCF, 12);
    chk("lu_InstrD_go", bus.InstrD, addi(8, 0, 8));
    chk("lu_RdE_add", bus.RdE, 7);
    chk("lu_Rs1E_add", bus.Rs1E, 6);
    chk("lu_RdW_lw", bus.RdW, 6);
    drive(NOP, 32'd16);
    step();
    chk("lu_RegWriteW_bubble", bus.RegWriteW, 0);
    chk("lu_Retired5", bus.RetiredCnt, 1);
    chk("lu_Bubble5", bus.BubbleCnt, 4);
    step();
    chk("lu_RdW_add", bus.RdW, 7);
    chk("lu_Bubble6", bus.BubbleCnt, 5);
    chk("lu_Retired6", bus.RetiredCnt, 1);

    // Branch taken: flush D and E for one edge, redirect to 0x100.
    do_reset();
    drive(addi(1, 0, 1), 32'd4);
    step();
    drive(addi(2, 0, 2), 32'd8);
    step();
    drive(addi(3, 0, 3), 32'h100);
    hazards(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("br_ValidD", bus.ValidD, 0);
    chk("br_InstrD", bus.InstrD, NOP);
    chk("br_PCD", bus.PCD, 0);
    chk("br_RdE", bus.RdE, 0);
    chk("br_RegWriteE", bus.RegWriteE, 0);
    chk("br_PCF", bus.PCF, 32'h100);
    chk("br_RdM", bus.RdM, 1);
    hazards(1'b0, 1'b0, 1'b0, 1'b0);
    drive(addi(4, 0, 4), 32'h104);
    step();
    chk("br_InstrD_target", bus.InstrD, addi(4, 0, 4));
    chk("br_RegWriteE_invD", bus.RegWriteE, 0);
    chk("br_RdW_1", bus.RdW, 1);
    drive(NOP, 32'h108);
    step();
    chk("br_RegWriteW_b1", bus.RegWriteW, 0);
    step();
    chk("br_RegWriteW_b2", bus.RegWriteW, 0);
    step();
    chk("br_RdW_4", bus.RdW, 4);
    chk("br_Bubble7", bus.BubbleCnt, 6);
    step();
    chk("br_Retired8", bus.RetiredCnt, 2);

    // StallD and FlushD together: flush wins.
    do_reset();
    drive(addi(1, 0, 1), 32'd4);
    step();
    drive(addi(2, 0, 2), 32'd8);
    hazards(1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk("sf_InstrD", bus.InstrD, NOP);
    chk("sf_ValidD", bus.ValidD, 0);
    chk("sf_RdE", bus.RdE, 1);
    hazards(1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with x7 sitting in M.
    do_reset();
    drive(addi(7, 1, 0), 32'd4);
    step();
    drive(NOP, 32'd8);
    step();
    drive(NOP, 32'd12);
    step();
    chk("ar_RdM_pre", bus.RdM, 7);
    chk("ar_RegWriteM_pre", bus.RegWriteM, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_RdM", bus.RdM, 0);
    chk("ar_RegWriteM", bus.RegWriteM, 0);
    chk("ar_PCF", bus.PCF, 0);
    chk("ar_ValidD", bus.ValidD, 0);
    chk("ar_Bubble", bus.BubbleCnt, 0);
    chk("ar_Retired", bus.RetiredCnt, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(addi(9, 0, 0), 32'd4);
    step();
    drive(NOP, 32'd8);
    repeat (3) step();
    chk("ar_RdW_first", bus.RdW, 9);
    chk("ar_RegWriteW_first", bus.RegWriteW, 1);

    // Saturation: 20 valid instructions retire; the 4-bit counter pins at 4'hF.
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      drive(NOP, 32'(4 * k));
      step();
      if (k == 19) chk("sat_Retired4_at15", bus4.RetiredCnt, 4'hF);
    end
    chk("sat_Retired4", bus4.RetiredCnt, 4'hF);
    chk("sat_Bubble4", bus4.BubbleCnt, 4);
    chk("sat_Retired32", bus.RetiredCnt, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
